// File: rtl/cale_de_date_div.sv
// Sequential restoring divider: unsigned OpA / OpB, one quotient bit per clock.
// load starts an operation from IDLE or DONE, busy marks RUN, ready marks DONE.
module cale_de_date_div #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [width-1:0] OpA,
  input  logic [width-1:0] OpB,
  output logic [width-1:0] quot,
  output logic [width-1:0] rem,
  output logic             busy,
  output logic             ready,
  output logic             div_zero,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(width + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(width - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Handshake: load is accepted on any rising edge where state is IDLE or DONE;
  // it is ignored in RUN. ready is high exactly while quot/rem/div_zero are valid.
  state_e state_q, state_d;

  logic [width-1:0] a_q, b_q;
  logic [width:0]   r_q;
  logic [CW-1:0]    cnt_q;
  logic [width-1:0] quot_q, rem_q;
  logic             dz_q;

  logic             accept;
  logic             last_iter;
  logic [width:0]   rs;
  logic [width:0]   diff;
  logic             ge;
  logic [width:0]   r_nxt;
  logic [width-1:0] a_nxt;

  assign accept    = load && (state_q != S_RUN);
  assign last_iter = (cnt_q == CNT_LAST);

  // A carry out of R would also mean Rs >= B; folding it in keeps R's top bit live.
  assign rs    = {r_q[width-1:0], a_q[width-1]};
  assign diff  = rs - {1'b0, b_q};
  assign ge    = r_q[width] || (rs >= {1'b0, b_q});
  assign r_nxt = ge ? diff : rs;
  assign a_nxt = {a_q[width-2:0], ge};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (load) begin
          state_d = (OpB == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_iter) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == S_RUN);
    ready     = (state_q == S_DONE);
    state_dbg = state_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      r_q    <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dz_q   <= 1'b0;
    end else if (accept) begin
      if (OpB != '0) begin
        a_q   <= OpA;
        b_q   <= OpB;
        r_q   <= '0;
        cnt_q <= '0;
      end else begin
        quot_q <= '1;
        rem_q  <= OpA;
        dz_q   <= 1'b1;
      end
    end else if (state_q == S_RUN) begin
      a_q   <= a_nxt;
      r_q   <= r_nxt;
      cnt_q <= cnt_q + CW'(1);
      // Outputs only ever change here, so RUN never exposes partial values.
      if (last_iter) begin
        quot_q <= a_nxt;
        rem_q  <= r_nxt[width-1:0];
        dz_q   <= 1'b0;
      end
    end
  end

  assign quot     = quot_q;
  assign rem      = rem_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_cale_de_date_div.sv
// Self-checking bench for cale_de_date_div: directed scenarios plus a random sweep,
// with expected {div_zero, quot, rem} queued at load time and popped at ready.
module tb_cale_de_date_div;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         load;
  logic [W-1:0] OpA, OpB;
  logic [W-1:0] quot, rem;
  logic         busy, ready, div_zero;
  logic [1:0]   state_dbg;

  int checks = 0;
  int errors = 0;
  logic [2*W:0] exp_q[$];

  cale_de_date_div #(.width(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .OpA      (OpA),
    .OpB      (OpB),
    .quot     (quot),
    .rem      (rem),
    .busy     (busy),
    .ready    (ready),
    .div_zero (div_zero),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Drives a one-cycle load and queues the expected result; returns at the
  // falling edge right after the accepting rising edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    load = 1'b1;
    OpA  = a;
    OpB  = b;
    if (b == '0) exp_q.push_back({1'b1, {W{1'b1}}, a});
    else         exp_q.push_back({1'b0, a / b, a % b});
    @(negedge clk);
    load = 1'b0;
    OpA  = W'($urandom);
    OpB  = W'($urandom);
  endtask

  // exp_lat = rising edges after the accepting edge until ready is visible
  // (0 for divide-by-zero). inj_at >= 0 pulses a spurious 9/3 load at that point.
  task automatic wait_result(input int exp_lat, input int inj_at, input string name);
    int lat;
    int busy_cnt;
    logic [2*W:0] exp;
    lat = 0;
    busy_cnt = 0;
    if (exp_lat > 0) begin
      checks++;
      if (ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s start: ready=%b busy=%b expected ready=0 busy=1", name, ready, busy);
      end
    end
    while (ready !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cnt++;
      if (lat == inj_at) begin
        load = 1'b1;
        OpA  = 8'd9;
        OpB  = 8'd3;
      end
      @(negedge clk);
      load = 1'b0;
      lat++;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d edges expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (busy_cnt != exp_lat || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy: busy cycles %0d (busy now %b) expected %0d (0)", name, busy_cnt, busy, exp_lat);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: result with empty expected queue", name);
    end else begin
      exp = exp_q.pop_front();
      if ({div_zero, quot, rem} !== exp) begin
        errors++;
        $display("FAIL %s result: dz=%b quot=%0d rem=%0d expected dz=%b quot=%0d rem=%0d",
                 name, div_zero, quot, rem, exp[2*W], exp[2*W-1:W], exp[W-1:0]);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    load  = 1'b0;
    OpA   = '0;
    OpB   = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({quot, rem, busy, ready, div_zero, state_dbg} !== '0) begin
      errors++;
      $display("FAIL reset: quot=%0d rem=%0d busy=%b ready=%b dz=%b state=%0d expected all 0",
               quot, rem, busy, ready, div_zero, state_dbg);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL reset idle: busy=%b ready=%b expected 0 0", busy, ready);
    end
  endtask

  task automatic test_basic();
    start_op(8'd100, 8'd7);
    wait_result(W, -1, "basic");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (ready !== 1'b1 || quot !== 8'd14 || rem !== 8'd2 || div_zero !== 1'b0) begin
        errors++;
        $display("FAIL basic hold: ready=%b quot=%0d rem=%0d dz=%b expected 1 14 2 0",
                 ready, quot, rem, div_zero);
      end
    end
  endtask

  task automatic test_boundary();
    logic [W-1:0] ta[5];
    logic [W-1:0] tb[5];
    ta = '{8'd255, 8'd255, 8'd5, 8'd0, 8'd128};
    tb = '{8'd1,   8'd255, 8'd9, 8'd3, 8'd128};
    for (int i = 0; i < 5; i++) begin
      start_op(ta[i], tb[i]);
      wait_result(W, -1, "boundary");
    end
  endtask

  task automatic test_div_zero();
    start_op(8'd42, 8'd0);
    wait_result(0, -1, "div_zero");
    checks++;
    if (quot !== 8'd255 || rem !== 8'd42 || div_zero !== 1'b1) begin
      errors++;
      $display("FAIL div_zero value: quot=%0d rem=%0d dz=%b expected 255 42 1", quot, rem, div_zero);
    end
    start_op(8'd10, 8'd3);
    wait_result(W, -1, "after_div_zero");
  endtask

  task automatic test_load_in_run();
    start_op(8'd100, 8'd7);
    wait_result(W, 3, "load_in_run");
    checks++;
    if (quot !== 8'd14 || rem !== 8'd2) begin
      errors++;
      $display("FAIL load_in_run value: quot=%0d rem=%0d expected 14 2", quot, rem);
    end
  endtask

  task automatic test_back_to_back();
    // Previous scenario left the block in DONE; the load below is taken from there.
    start_op(8'd200, 8'd13);
    wait_result(W, -1, "back_to_back");
  endtask

  task automatic test_async_reset();
    start_op(8'd100, 8'd7);
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({quot, rem, busy, ready, div_zero} !== '0) begin
      errors++;
      $display("FAIL async_reset: quot=%0d rem=%0d busy=%b ready=%b dz=%b expected all 0",
               quot, rem, busy, ready, div_zero);
    end
    void'(exp_q.pop_back());
    @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || ready !== 1'b0 || state_dbg !== 2'd0) begin
        errors++;
        $display("FAIL async_reset idle: busy=%b ready=%b state=%0d expected 0 0 0", busy, ready, state_dbg);
      end
    end
    start_op(8'd77, 8'd4);
    wait_result(W, -1, "after_reset");
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int i = 0; i < 2000; i++) begin
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(1, 255));
      start_op(a, b);
      wait_result(W, -1, "random");
      checks++;
      if (int'(quot) * int'(b) + int'(rem) != int'(a) || rem >= b) begin
        errors++;
        $display("FAIL random invariant: %0d/%0d gave quot=%0d rem=%0d", a, b, quot, rem);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_div_zero();
    test_load_in_run();
    test_back_to_back();
    test_async_reset();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d expected results left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cale_de_date_div.md
Name: cale_de_date_div

Overview:
- Sequential restoring shift-subtract divider: unsigned OpA / OpB, one quotient bit per clock.
- Inverse datapath to the team's shift-add multiplier (cale_de_dateM). Same load/busy/ready style, so the same control unit and bench can drive either block.
- Owns its control FSM: a single load pulse starts an operation; ready flags the result.

Parameters:
width, 8, operand width in bits; quotient and remainder are width bits each.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset.
load  input  1  start request; sampled on a clock edge in IDLE or DONE.
OpA  input  width  dividend; sampled when load is accepted.
OpB  input  width  divisor; sampled when load is accepted.
quot  output  width  quotient, registered.
rem  output  width  remainder, registered.
busy  output  1  high while in state RUN.
ready  output  1  high while in state DONE; result is valid.
div_zero  output  1  high in DONE when the accepted divisor was 0.

Behaviour:
- Reset (reset=0, takes effect immediately, no clock needed):
  - state=IDLE.
  - quot, rem, busy, ready, div_zero = 0.
  - Internal A, B, R and cnt cleared.
- Internal registers:
  - A: width bits, dividend that becomes the quotient.
  - B: width bits, divisor.
  - R: width+1 bits, partial remainder.
  - cnt: $clog2(width+1) bits, iteration counter.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - load=0: stay in IDLE.
  - load=1, OpB!=0: A<=OpA, B<=OpB, R<=0, cnt<=0; go to RUN.
  - load=1, OpB==0: go straight to DONE with quot<=all ones, rem<=OpA, div_zero<=1.
- RUN: one iteration per edge.
  - Rs = {R[width-1:0], A[width-1]}; A shifts left by one.
  - If Rs >= {1'b0,B}: R<=Rs-B and A[0]<=1. Otherwise: R<=Rs and A[0]<=0.
  - Compare and subtract are width+1 bits wide and unsigned.
  - cnt<=cnt+1.
  - On the iteration where cnt==width-1: go to DONE, quot<=new A, rem<=new R[width-1:0], div_zero<=0.
- DONE:
  - ready=1. quot, rem and div_zero hold until the next accepted load.
  - load=1 is accepted exactly as in IDLE; this is the back-to-back path.
  - ready drops on the same edge that accepts the load.
  - load=0: stay in DONE indefinitely. There is no automatic return to IDLE.
- Latency: load accepted at edge 0 → busy from edge 0 through edge width → ready visible after edge width (width clocks). Divide-by-zero: ready visible after edge 0 (1 clock).
- load during RUN: ignored. OpA/OpB changes during RUN have no effect.
- quot/rem during RUN: hold the previous result (0 after reset). They never show partial values.
- busy and ready are never both high. Both are low only in IDLE.
- reset low mid-RUN: the operation is aborted immediately, all outputs go to 0, and no result is produced.
- Invariant for every non-zero divisor: OpA == quot*OpB + rem, and rem < OpB.

Test Plan:
- Reset, then OpA=100, OpB=7, one-cycle load → busy for 8 clocks, then ready=1, quot=14, rem=2, div_zero=0; held for ≥5 idle clocks.
- Boundary operands (width=8): 255/1 → quot=255, rem=0. 255/255 → quot=1, rem=0. 5/9 → quot=0, rem=5. 0/3 → quot=0, rem=0. Each completes in exactly 8 clocks.
- Divide by zero: OpA=42, OpB=0 → one clock later ready=1, div_zero=1, quot=255, rem=42, busy never asserted. A following 10/3 load → quot=3, rem=1, div_zero=0.
- load pulsed again at clock 3 of RUN with OpA=9, OpB=3 → ignored; the original 100/7 result (14, 2) appears on schedule.
- Back-to-back: load held high in DONE with 200/13 → ready falls on that edge; 8 clocks later quot=15, rem=5.
- reset driven low asynchronously mid-RUN (between edges) → outputs 0 immediately. After release, state is IDLE, and a fresh 77/4 gives quot=19, rem=1.
- Random sweep: 2000 random operand pairs with non-zero divisor → every result satisfies OpA == quot*OpB + rem and rem < OpB.
